// File: rtl/wishbone_uart.sv
// Wishbone-attached 8N1 UART: a TX FIFO feeds a serializer, and an RX deserializer
// feeds a one-entry holding register. A status register carries write-1-to-clear sticky flags.
module wishbone_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cycle,
  input  logic        wb_strobe,
  input  logic [31:0] wb_address,
  input  logic [3:0]  wb_select,
  input  logic        wb_write_enable,
  input  logic [31:0] wb_data_in,
  output logic [31:0] wb_data_out,
  output logic        wb_ack,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic unused_bits;
  assign unused_bits = &{1'b0, wb_address[31:4], wb_address[1:0], wb_select[3:1], wb_data_in[31:8]};

  // Bus decode; every side effect keys off req, which is low during the ack cycle.
  logic       req, wr, rd, push_req, rx_rd, st_clr;
  logic [1:0] reg_sel;
  assign req      = wb_cycle & wb_strobe & ~wb_ack;
  assign reg_sel  = wb_address[3:2];
  assign wr       = req & wb_write_enable;
  assign rd       = req & ~wb_write_enable;
  assign push_req = wr && reg_sel == 2'd0 && wb_select[0];
  assign rx_rd    = rd && reg_sel == 2'd1;
  assign st_clr   = wr && reg_sel == 2'd2 && wb_select[0];

  logic [7:0] fifo_mem [TX_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, pop, push;
  logic [1:0]  tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop        = (tx_state == ST_IDLE) && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);

  // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= wb_data_in[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // uart_tx is a registered output so the line stays glitch-free between bit boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: if (pop) begin
          tx_shift <= fifo_mem[rd_ptr[PW-1:0]];
          tx_cnt   <= '0;
          uart_tx  <= 1'b0;
          tx_state <= ST_START;
        end
        ST_START: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          uart_tx  <= tx_shift[0];
          tx_state <= ST_DATA;
        end else tx_cnt <= tx_cnt + CW'(1);
        ST_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            uart_tx  <= 1'b1;
            tx_state <= ST_STOP;
          end else begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            uart_tx  <= tx_shift[1];
            tx_bit   <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt + CW'(1);
        default: if (tx_cnt == BIT_LAST) begin
          tx_cnt   <= '0;
          tx_state <= ST_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
      endcase
    end
  end

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, rx_overrun, frame_err, tx_ovf;
  logic          rx_done, rx_good, rx_bad;

  assign rx_done = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST);
  assign rx_good = rx_done && rx_s2;
  assign rx_bad  = rx_done && !rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        ST_IDLE: if (rx_prev && !rx_s2) begin
          rx_cnt   <= '0;
          rx_state <= ST_START;
        end
        ST_START: if (rx_cnt == HALF_LAST) begin
          // Mid-start re-check; a line already back high was only a glitch.
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        ST_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= ST_STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + CW'(1);
        default: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= ST_IDLE;
        end else rx_cnt <= rx_cnt + CW'(1);
      endcase
    end
  end

  // A completing byte beats a same-cycle RXDATA read: the read sees the old byte, no overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_ovf     <= 1'b0;
    end else begin
      if (rx_good) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end
      rx_overrun <= (rx_overrun & ~(st_clr & wb_data_in[3])) | (rx_good & rx_valid & ~rx_rd);
      frame_err  <= (frame_err  & ~(st_clr & wb_data_in[4])) | rx_bad;
      tx_ovf     <= (tx_ovf     & ~(st_clr & wb_data_in[5])) | (push_req & ~push);
    end
  end

  logic [31:0] rd_data;
  logic        tx_empty;
  assign tx_empty = fifo_empty && (tx_state == ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd1:    if (rx_valid) rd_data = {23'b0, 1'b1, rx_byte};
      2'd2:    rd_data = {26'b0, tx_ovf, frame_err, rx_overrun, rx_valid, tx_empty, fifo_full};
      default: rd_data = '0;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack      <= 1'b0;
      wb_data_out <= '0;
    end else begin
      wb_ack      <= req;
      wb_data_out <= rd ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_wishbone_uart.sv
// Directed bench for wishbone_uart with CLKS_PER_BIT=4, TX_DEPTH=4: bus accesses,
// a serial TX monitor, and an RX line driver.
module tb_wishbone_uart;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_RX  = 32'h1000_0004;
  localparam logic [31:0] A_ST  = 32'h1000_0008;
  localparam logic [31:0] A_RES = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cycle = 1'b0, wb_strobe = 1'b0, wb_write_enable = 1'b0;
  logic [31:0] wb_address = '0, wb_data_in = '0;
  logic [3:0]  wb_select = '0;
  logic [31:0] wb_data_out;
  logic        wb_ack, uart_tx;
  logic        uart_rx = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  wishbone_uart #(.CLKS_PER_BIT(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_cycle(wb_cycle), .wb_strobe(wb_strobe), .wb_address(wb_address),
    .wb_select(wb_select), .wb_write_enable(wb_write_enable), .wb_data_in(wb_data_in),
    .wb_data_out(wb_data_out), .wb_ack(wb_ack),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Serial TX monitor: records each completed frame's byte, shape errors and preceding idle gap.
  logic [7:0] mon_bytes [$];
  int         mon_gaps  [$];
  int         mon_errs  [$];
  int         mon_c = -1, mon_idle = 0, mon_err = 0, mon_gap = 0;
  logic [7:0] mon_data = '0;
  logic       mon_bit = 1'b1;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_c = -1;
      mon_idle = 0;
    end else if (mon_c < 0) begin
      if (uart_tx === 1'b0) begin
        mon_c = 0; mon_err = 0; mon_gap = mon_idle;
      end else mon_idle++;
    end else begin
      mon_c++;
      if (mon_c < 4) begin
        if (uart_tx !== 1'b0) mon_err++;
      end else if (mon_c < 36) begin
        if ((mon_c % 4) == 0) mon_bit = uart_tx;
        else if (uart_tx !== mon_bit) mon_err++;
        if ((mon_c % 4) == 2) mon_data[(mon_c - 4) / 4] = uart_tx;
      end else begin
        if (uart_tx !== 1'b1) mon_err++;
        if (mon_c == 39) begin
          mon_bytes.push_back(mon_data);
          mon_gaps.push_back(mon_gap);
          mon_errs.push_back(mon_err);
          mon_c = -1;
          mon_idle = 0;
        end
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    wb_cycle = 1'b1; wb_strobe = 1'b1; wb_address = addr;
    wb_write_enable = we; wb_data_in = wdata; wb_select = sel;
    lat = 0; rdata = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin
        lat = i; rdata = wb_data_out;
        break;
      end
    end
    wb_cycle = 1'b0; wb_strobe = 1'b0; wb_write_enable = 1'b0;
    if (lat == 0) check("ack_timeout", 32'(lat), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d; int l;
    wb_xfer(addr, 1'b1, wdata, 4'hF, d, l);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] rdata);
    int l;
    wb_xfer(addr, 1'b0, '0, 4'hF, rdata, l);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_mon(input int n);
    for (int i = 0; i < 600 && mon_bytes.size() < n; i++) @(posedge clk);
    check("tx_frame_count", 32'(mon_bytes.size()), 32'(n));
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] rd;
  int          lat, base;

  initial begin
    // 1. Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, wb_ack}, 32'd0);
    check("rst_dout", wb_data_out, 32'd0);
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    @(negedge clk); rst = 1'b0;
    wb_xfer(A_ST, 1'b0, '0, 4'hF, rd, lat);
    check("status_reset", rd, 32'h02);
    check("read_ack_lat", 32'(lat), 32'd1);
    @(posedge clk); #1;
    check("ack_pulse", {31'b0, wb_ack}, 32'd0);
    check("dout_idle", wb_data_out, 32'd0);

    // 2. Single byte
    base = mon_bytes.size();
    wb_xfer(A_TX, 1'b1, 32'hA5, 4'h1, rd, lat);
    check("write_ack_lat", 32'(lat), 32'd1);
    wb_read(A_ST, rd);
    check("status_busy", rd, 32'h00);
    wb_read(A_TX, rd);
    check("txdata_read", rd, 32'h0);
    wait_mon(base + 1);
    check("tx_byte_a5", {24'b0, mon_bytes[base]}, 32'hA5);
    check("tx_shape_a5", 32'(mon_errs[base]), 32'd0);
    wb_read(A_ST, rd);
    check("status_done", rd, 32'h02);

    // 3. Burst of six writes into a four-entry FIFO
    base = mon_bytes.size();
    for (int i = 0; i < 6; i++) wb_write(A_TX, 32'h11 + 32'(i));
    wb_read(A_ST, rd);
    check("status_full_ovf", rd, 32'h21);
    wait_mon(base + 5);
    for (int i = 0; i < 5; i++) begin
      check("burst_byte", {24'b0, mon_bytes[base + i]}, 32'h11 + 32'(i));
      check("burst_shape", 32'(mon_errs[base + i]), 32'd0);
      if (i > 0) check("burst_gap", 32'(mon_gaps[base + i]), 32'd1);
    end
    repeat (60) @(negedge clk);
    check("no_sixth_frame", 32'(mon_bytes.size()), 32'(base + 5));
    wb_read(A_ST, rd);
    check("status_ovf", rd, 32'h22);
    wb_write(A_ST, 32'h20);
    wb_read(A_ST, rd);
    check("status_ovf_clr", rd, 32'h02);

    // 4. Receive, read-clear, overrun
    send_rx(8'h3C, 1'b1);
    wb_read(A_RES, rd);
    check("reserved_read", rd, 32'h0);
    wb_read(A_RX, rd);
    check("rx_3c", rd, 32'h13C);
    wb_read(A_RX, rd);
    check("rx_empty", rd, 32'h0);
    send_rx(8'h5A, 1'b1);
    send_rx(8'h6B, 1'b1);
    wb_read(A_ST, rd);
    check("status_overrun", rd, 32'h0E);
    wb_write(A_ST, 32'h08);
    wb_read(A_ST, rd);
    check("overrun_clr", rd, 32'h06);
    wb_read(A_RX, rd);
    check("rx_6b", rd, 32'h16B);

    // 5. Framing error, then a one-cycle glitch
    send_rx(8'h81, 1'b0);
    wb_read(A_ST, rd);
    check("status_frame_err", rd, 32'h12);
    wb_read(A_RX, rd);
    check("rx_after_ferr", rd, 32'h0);
    wb_write(A_ST, 32'h10);
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (50) @(negedge clk);
    wb_read(A_ST, rd);
    check("glitch_rejected", rd, 32'h02);

    // 6. Reset in the middle of both frames
    base = mon_bytes.size();
    wb_write(A_TX, 32'h77);
    wb_write(A_TX, 32'h78);
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk); uart_rx = 1'b1;
    repeat (4) @(negedge clk); uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_tx_immediate", {31'b0, uart_tx}, 32'd1);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wb_read(A_ST, rd);
    check("status_after_rst", rd, 32'h02);
    check("aborted_frame", 32'(mon_bytes.size()), 32'(base));
    wb_write(A_TX, 32'hC3);
    wait_mon(base + 1);
    check("tx_after_rst", {24'b0, mon_bytes[base]}, 32'hC3);
    check("tx_shape_rst", 32'(mon_errs[base]), 32'd0);
    send_rx(8'h96, 1'b1);
    wb_read(A_RX, rd);
    check("rx_after_rst", rd, 32'h196);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
